idct_2d_seq: RTL
================

Name: idct_2d_seq

Overview:
- 8x8 two-dimensional inverse DCT: the decode-side counterpart of the row/column butterfly DCT block.
- Accepts a full 8x8 coefficient matrix in one cycle and returns the reconstructed 8x8 sample matrix.
- Uses a single time-multiplexed 1-D IDCT row engine (8 outputs per cycle), run 8 cycles on rows, then 8 cycles on columns through an internal transpose buffer.
- Sits between coefficient dequantisation and the pixel writeback path.

Parameters:
- DATA_W, 32, width of every matrix element (signed two's complement).
- COEF_FRAC, 12, fractional bits of the cosine table and of the rounding shift.
- ACC_W, 48, accumulator width of each 8-term dot product.

Ports:
- CLOCK  in  1  rising-edge clock.
- RESET  in  1  synchronous, active-low reset.
- INPUT_DATA_ENABLE  in  1  coefficient matrix valid; sampled only while INPUT_READY=1.
- INPUT_DATA  in  [DATA_W-1:0][8][8]  coefficient matrix, [row][col] = [v][u].
- INPUT_READY  out  1  high when state is IDLE.
- OUTPUT_DATA_ENABLE  out  1  one-cycle pulse marking a new OUTPUT_DATA.
- OUTPUT_DATA  out  [DATA_W-1:0][8][8]  reconstructed samples, [row][col] = [y][x]; held until the next block completes.

Behaviour:
- Reset (RESET=0 at an edge):
  - state=IDLE, counter=0.
  - OUTPUT_DATA_ENABLE=0, all OUTPUT_DATA elements and internal buffers =0.
  - INPUT_READY=1 in the following cycle.
- FSM states:
  - IDLE -> ROW on an edge with INPUT_DATA_ENABLE=1; INPUT_DATA is latched into the input buffer and cnt=0.
  - ROW: each edge computes 1-D IDCT of input row cnt and writes the result into transpose buffer T[cnt][0..7]. cnt 7 -> COL with cnt=0.
  - COL: each edge computes 1-D IDCT of column cnt, T[0..7][cnt], and writes the result to OUTPUT_DATA[0..7][cnt]. cnt 7 -> IDLE.
- OUTPUT_DATA update and pulse:
  - OUTPUT_DATA columns update progressively during COL.
  - On the COL cnt=7 edge, OUTPUT_DATA_ENABLE is registered high for exactly one cycle.
- Timing:
  - Accept edge E0; row pass E1..E8; column pass E9..E16.
  - OUTPUT_DATA_ENABLE high in the cycle after E16 (latency 16 edges). INPUT_READY is high again in that same cycle.
  - Max throughput is 1 block per 17 cycles.
- 1-D IDCT: x[n] = sum over k=0..7 of C[k][n]*X[k].
  - C[k][n] = round(2^COEF_FRAC * 0.5 * a(k) * cos((2n+1)k*pi/16)), with a(0)=1/sqrt2 and a(k>0)=1.
  - Q12 magnitudes: 1448 (k=0 and k=4), 2009/1703/1138/400 (odd k), 1892/784 (k=2,6), with signs per the cosine.
  - Table is a constant generated from the formula; no ROM port.
- Arithmetic:
  - Products are signed DATA_W x 14-bit, sign-extended to ACC_W; the 8 terms are summed in ACC_W.
  - Add 2^(COEF_FRAC-1), arithmetic shift right by COEF_FRAC (floor), truncate to DATA_W (wrap, no saturation).
  - Identical rounding in the row pass and the column pass.
- Handshake rules:
  - INPUT_DATA_ENABLE while INPUT_READY=0 is ignored; the block is dropped, not queued, and no state is disturbed.
  - INPUT_DATA need only be valid on the accept edge.
- Reset mid-operation: aborts immediately. No OUTPUT_DATA_ENABLE pulse for the aborted block; OUTPUT_DATA cleared to 0.
- Enable held high continuously: a new block is accepted on every IDLE edge. This means back-to-back blocks with a 1-cycle IDLE gap.

Test Plan:
- Reset check: hold RESET=0 for 3 cycles, release -> OUTPUT_DATA all 0, OUTPUT_DATA_ENABLE=0, INPUT_READY=1. Nothing changes with INPUT_DATA_ENABLE=0 for 40 cycles.
- DC block: X[0][0]=64, rest 0, accepted at E0 -> row 0 of T = 23 (others 0), then all 64 outputs = 8. OUTPUT_DATA_ENABLE high exactly one cycle after E16; INPUT_READY low E1..E16.
- Negative DC: X[0][0]=-64 -> all outputs -8 (intermediate -23), verifying floor-shift rounding. All-zero input -> all 0 with the normal pulse.
- Busy drop: accept DC=64 at E0, present DC=640 with enable at E5 -> single pulse after E16 with all 8. The following block, presented at the first ready cycle, yields all 80.
- Reset mid-block: accept DC=64, drive RESET=0 at E10 -> no pulse, OUTPUT_DATA all 0. Next block accepted normally after release.
- Round trip: random 8-bit samples in the range -128..127 through the team's forward DCT block, then through this block -> every output within ±1 of the original. Sweep 1000 blocks back-to-back with enable held high.

Source files
------------

// File: rtl/idct_2d_seq_if.sv
`default_nettype none
// idct_2d_seq_if: coefficient-in / sample-out bus of the 8x8 inverse DCT.
// Rev 1.0
interface idct_2d_seq_if #(
  parameter int DATA_W = 32
) ();
  logic                             INPUT_DATA_ENABLE;
  logic [7:0][7:0][DATA_W-1:0]      INPUT_DATA;
  logic                             INPUT_READY;
  logic                             OUTPUT_DATA_ENABLE;
  logic [7:0][7:0][DATA_W-1:0]      OUTPUT_DATA;

  modport master (
    output INPUT_DATA_ENABLE,
    output INPUT_DATA,
    input  INPUT_READY,
    input  OUTPUT_DATA_ENABLE,
    input  OUTPUT_DATA
  );

  modport slave (
    input  INPUT_DATA_ENABLE,
    input  INPUT_DATA,
    output INPUT_READY,
    output OUTPUT_DATA_ENABLE,
    output OUTPUT_DATA
  );
endinterface
`default_nettype wire

// File: rtl/idct_2d_seq.sv
`default_nettype none
// idct_2d_seq: 8x8 2-D inverse DCT using one shared 1-D engine, 8 row passes then 8 column passes.
// Rev 1.0
module idct_2d_seq #(
  parameter int DATA_W    = 32,
  parameter int COEF_FRAC = 12,
  parameter int ACC_W     = 48
) (
  input  logic         CLOCK,
  input  logic         RESET,
  idct_2d_seq_if.slave bus
);

  localparam int CW = 14;
  localparam int PW = DATA_W + CW;

  typedef logic signed [DATA_W-1:0] elem_t;
  typedef logic signed [CW-1:0]     coef_t;
  typedef logic signed [PW-1:0]     prod_t;
  typedef logic [7:0][7:0][CW-1:0]  tab_t;
  typedef logic [7:0][7:0][DATA_W-1:0] mat_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROW  = 2'd1,
    COL  = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] RND = ACC_W'(64'd1 << (COEF_FRAC - 1));

  // Q12 value of 0.5*cos(m*pi/16) for m = 0..8
  function automatic int cos_mag(input int m);
    case (m)
      0:       cos_mag = 2048;
      1:       cos_mag = 2009;
      2:       cos_mag = 1892;
      3:       cos_mag = 1703;
      4:       cos_mag = 1448;
      5:       cos_mag = 1138;
      6:       cos_mag = 784;
      7:       cos_mag = 400;
      default: cos_mag = 0;
    endcase
  endfunction

  // C[k][n]: fold (2n+1)k*pi/16 into the first quadrant and track the sign of the cosine
  function automatic tab_t build_tab();
    tab_t t;
    int   m;
    int   mag;
    t = '0;
    for (int k = 0; k < 8; k++) begin
      for (int n = 0; n < 8; n++) begin
        if (k == 0) begin
          mag = 1448;
        end else begin
          m = ((2 * n + 1) * k) % 32;
          if (m > 16) m = 32 - m;
          if (m > 8) mag = -cos_mag(16 - m);
          else       mag = cos_mag(m);
        end
        t[k][n] = CW'(mag);
      end
    end
    return t;
  endfunction

  localparam tab_t C_TAB = build_tab();

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  cnt;
  logic [2:0]  cnt_nxt;
  mat_t        in_buf;
  mat_t        t_buf;
  mat_t        out_data;
  logic        out_en;
  elem_t       eng_in  [8];
  elem_t       eng_out [8];

  assign bus.INPUT_READY        = (state == IDLE);
  assign bus.OUTPUT_DATA_ENABLE = out_en;
  assign bus.OUTPUT_DATA        = out_data;

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.INPUT_DATA_ENABLE) begin
          state_nxt = ROW;
          cnt_nxt   = 3'd0;
        end
      end
      ROW: begin
        cnt_nxt = cnt + 3'd1;
        if (cnt == 3'd7) state_nxt = COL;
      end
      COL: begin
        cnt_nxt = cnt + 3'd1;
        if (cnt == 3'd7) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Row pass reads the latched coefficients, column pass reads the transpose buffer
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      if (state == COL) eng_in[i] = elem_t'(t_buf[i][cnt]);
      else              eng_in[i] = elem_t'(in_buf[cnt][i]);
    end
  end

  for (genvar n = 0; n < 8; n++) begin : g_eng
    logic signed [ACC_W-1:0] acc;

    always_comb begin
      acc = RND;
      for (int k = 0; k < 8; k++) begin
        acc = acc + ACC_W'(prod_t'(eng_in[k]) * prod_t'(coef_t'(C_TAB[k][n])));
      end
    end

    assign eng_out[n] = DATA_W'(acc >>> COEF_FRAC);
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      in_buf   <= '0;
      t_buf    <= '0;
      out_data <= '0;
      out_en   <= 1'b0;
    end else begin
      out_en <= (state == COL) && (cnt == 3'd7);
      if (state == IDLE && bus.INPUT_DATA_ENABLE) begin
        in_buf <= bus.INPUT_DATA;
      end
      if (state == ROW) begin
        for (int n = 0; n < 8; n++) t_buf[cnt][n] <= eng_out[n];
      end
      if (state == COL) begin
        for (int n = 0; n < 8; n++) out_data[n][cnt] <= eng_out[n];
      end
    end
  end

endmodule
`default_nettype wire
